instr_queue_mw: RTL and testbench

- Parametrised multi-issue instruction queue between fetch and dispatch/reservation stations in the superscalar core.
- Generalises the current single-entry `iq_valid`/`instruction` handoff into a circular buffer.
- Fetch pushes one instruction plus PC per cycle. Dispatch pops 0..DISPATCH_WIDTH instructions per cycle in program order.
- A flush port discards all contents on branch mispredict.

---
 rtl/instr_queue_mw.sv | 126 ++++++++++++
 tb/tb_instr_queue_mw.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_mw.sv
// Multi-issue instruction queue between fetch and dispatch.
// Fetch pushes one instr+pc per cycle into a circular buffer. Dispatch sees
// the DISPATCH_WIDTH oldest entries and pops 0..DISPATCH_WIDTH of them.
// Flush empties the queue on a mispredict.
// Optional: define IQ_BYPASS_EN so that an empty queue forwards the incoming
// entry combinationally to slot 0.

// One dispatch slot: the entry is forced to zero when the slot is not valid.
module iq_lane #(
    parameter int XLEN = 32
) (
    input  logic            vld,
    input  logic [XLEN-1:0] instr_raw,
    input  logic [XLEN-1:0] pc_raw,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);
    assign instr = vld ? instr_raw : '0;
    assign pc    = vld ? pc_raw    : '0;
endmodule

module instr_queue_mw #(
    parameter int DEPTH          = 8,
    parameter int XLEN           = 32,
    parameter int DISPATCH_WIDTH = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_n,
    input  logic                               enq_valid,
    input  logic [XLEN-1:0]                    enq_instr,
    input  logic [XLEN-1:0]                    enq_pc,
    output logic                               enq_ready,
    output logic [DISPATCH_WIDTH-1:0]          deq_valid,
    output logic [DISPATCH_WIDTH*XLEN-1:0]     deq_instr,
    output logic [DISPATCH_WIDTH*XLEN-1:0]     deq_pc,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0] deq_take,
    input  logic                               flush,
    output logic [$clog2(DEPTH+1)-1:0]         count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]                           head, tail;
    logic [DEPTH-1:0][XLEN-1:0]              mem_instr, mem_pc;
    logic [DISPATCH_WIDTH-1:0][XLEN-1:0]     slot_instr, slot_pc;
    logic [CW-1:0]                           take_req, take;
    logic                                    byp, byp_take, push;

    // Full check uses registered occupancy only, never the same-cycle take.
    assign enq_ready = (count != CW'(DEPTH));

`ifdef IQ_BYPASS_EN
    assign byp = (count == '0) && enq_valid;
`else
    assign byp = 1'b0;
`endif
    // A bypassed entry consumed in the same cycle never touches storage.
    assign byp_take = byp && (deq_take != '0);
    assign push     = enq_valid && enq_ready && !byp_take;

    // Over-take is clamped to occupancy so head never passes tail.
    assign take_req = CW'(deq_take);
    assign take     = (take_req > count) ? count : take_req;

    // Dispatch window: slot i reads entry (head+i) mod DEPTH.
    for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_lane
        logic [PW-1:0]   idx;
        logic            hit, lane_vld;
        logic [XLEN-1:0] raw_instr, raw_pc;

        assign idx = head + PW'(i);
        assign hit = CW'(i) < count;

        if (i == 0) begin : g_byp
            assign lane_vld  = hit | byp;
            assign raw_instr = byp ? enq_instr : mem_instr[idx];
            assign raw_pc    = byp ? enq_pc    : mem_pc[idx];
        end else begin : g_mem
            assign lane_vld  = hit;
            assign raw_instr = mem_instr[idx];
            assign raw_pc    = mem_pc[idx];
        end

        assign deq_valid[i] = lane_vld;

        iq_lane #(.XLEN(XLEN)) u_lane (
            .vld       (lane_vld),
            .instr_raw (raw_instr),
            .pc_raw    (raw_pc),
            .instr     (slot_instr[i]),
            .pc        (slot_pc[i])
        );
    end

    assign deq_instr = slot_instr;
    assign deq_pc    = slot_pc;

    // Pointer and occupancy update; flush wins over any push or pop.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(take);
            if (push)
                tail <= tail + PW'(1);
            count <= count + CW'(push) - take;
        end
    end

    // Entry storage; popped or flushed entries are left in place.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mem_instr <= '0;
            mem_pc    <= '0;
        end else if (push && !flush) begin
            mem_instr[tail] <= enq_instr;
            mem_pc[tail]    <= enq_pc;
        end
    end
endmodule

// File: tb/tb_instr_queue_mw.sv
// Scoreboard bench for instr_queue_mw (DEPTH=8, XLEN=32, DISPATCH_WIDTH=2).
module tb_instr_queue_mw;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int DW    = 2;
    localparam int TW    = $clog2(DW+1);
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ent_t;

    logic                 clk_in = 1'b0;
    logic                 rst_n;
    logic                 enq_valid;
    logic [XLEN-1:0]      enq_instr, enq_pc;
    logic                 enq_ready;
    logic [DW-1:0]        deq_valid;
    logic [DW*XLEN-1:0]   deq_instr, deq_pc;
    logic [TW-1:0]        deq_take;
    logic                 flush;
    logic [CW-1:0]        count;

    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;

    instr_queue_mw #(.DEPTH(DEPTH), .XLEN(XLEN), .DISPATCH_WIDTH(DW)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .enq_valid (enq_valid),
        .enq_instr (enq_instr),
        .enq_pc    (enq_pc),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_instr (deq_instr),
        .deq_pc    (deq_pc),
        .deq_take  (deq_take),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from a negedge: check the outputs against the
    // scoreboard before the edge, then retire/append entries in the model.
    task automatic cyc(input logic ev, input logic [XLEN-1:0] ins, input logic [XLEN-1:0] pc,
                       input int tk, input logic fl);
        int   n;
        logic byp;
        logic [DW-1:0] ev_vld;
        logic [XLEN-1:0] ei, ep;
        enq_valid = ev; enq_instr = ins; enq_pc = pc;
        deq_take = TW'(tk); flush = fl;
        #1;
        n = sb.size();
`ifdef IQ_BYPASS_EN
        byp = (n == 0) && ev;
`else
        byp = 1'b0;
`endif
        chk("count", 64'(count), 64'(n));
        chk("enq_ready", 64'(enq_ready), 64'(n != DEPTH));
        for (int i = 0; i < DW; i++) begin
            ev_vld[i] = (i < n) || (byp && i == 0);
            ei = (i < n) ? sb[i].instr : ((byp && i == 0) ? ins : '0);
            ep = (i < n) ? sb[i].pc    : ((byp && i == 0) ? pc  : '0);
            chk($sformatf("slot%0d_instr", i), 64'(deq_instr[i*XLEN +: XLEN]), 64'(ei));
            chk($sformatf("slot%0d_pc", i), 64'(deq_pc[i*XLEN +: XLEN]), 64'(ep));
        end
        chk("deq_valid", 64'(deq_valid), 64'(ev_vld));
        @(posedge clk_in);
        if (fl) begin
            sb.delete();
        end else if (!(byp && tk >= 1)) begin
            for (int k = 0; k < ((tk < n) ? tk : n); k++) void'(sb.pop_front());
            if (ev && n != DEPTH) sb.push_back('{instr: ins, pc: pc});
        end
        @(negedge clk_in);
    endtask

    task automatic idle(input int tk);
        cyc(1'b0, '0, '0, tk, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; enq_valid = 1'b0; enq_instr = '0; enq_pc = '0;
        deq_take = '0; flush = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(enq_ready), 64'd1);
        chk("rst_valid", 64'(deq_valid), 64'd0);
        chk("rst_instr", 64'(deq_instr), 64'd0);
        @(negedge clk_in); @(negedge clk_in);
        rst_n = 1'b1;

        // single push then pop
        cyc(1'b1, 32'h00158593, 32'h0, 0, 1'b0);
        chk("first_count", 64'(count), 64'd1);
        chk("first_valid", 64'(deq_valid), 64'b01);
        chk("first_instr", 64'(deq_instr[XLEN-1:0]), 64'h00158593);
        idle(1);
        chk("pop_count", 64'(count), 64'd0);

        // three pushes, take two
        cyc(1'b1, 32'h00158593, 32'h0, 0, 1'b0);
        cyc(1'b1, 32'h00260613, 32'h4, 0, 1'b0);
        cyc(1'b1, 32'h00368693, 32'h8, 0, 1'b0);
        idle(2);
        chk("after2_slot0", 64'(deq_instr[XLEN-1:0]), 64'h00368693);
        chk("after2_count", 64'(count), 64'd1);
        idle(1);

        // fill to full, 9th refused, push+take while full
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1000 + i, 32'(i * 4), 0, 1'b0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(enq_ready), 64'd0);
        cyc(1'b1, 32'h2009, 32'h20, 0, 1'b0);
        cyc(1'b1, 32'h2009, 32'h20, 2, 1'b0);
        chk("full_take_count", 64'(count), 64'd6);
        cyc(1'b1, 32'h2009, 32'h20, 0, 1'b0);
        chk("held_push_count", 64'(count), 64'd7);

        // wrap: drain, fill 8, take 6, push 4, read across 7->0
        for (int i = 0; i < 4; i++) idle(2);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h3000 + i, 32'h100 + 32'(i * 4), 0, 1'b0);
        for (int i = 0; i < 3; i++) idle(2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h4000 + i, 32'h200 + 32'(i * 4), 0, 1'b0);
        chk("wrap_count", 64'(count), 64'd6);
        for (int i = 0; i < 3; i++) idle(2);

        // flush with concurrent push and take
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h5000 + i, 32'h300 + 32'(i * 4), 0, 1'b0);
        cyc(1'b1, 32'h5555, 32'h3ff, 2, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(deq_valid), 64'd0);
        cyc(1'b1, 32'h00470713, 32'h400, 0, 1'b0);
        chk("post_flush_instr", 64'(deq_instr[XLEN-1:0]), 64'h00470713);

        // over-take clamp
        idle(2);
        chk("clamp_count", 64'(count), 64'd0);
        cyc(1'b1, 32'h6000, 32'h500, 0, 1'b0);
        cyc(1'b1, 32'h6001, 32'h504, 0, 1'b0);
        chk("clamp_head", 64'(deq_instr[XLEN-1:0]), 64'h6000);
        idle(2);

`ifdef IQ_BYPASS_EN
        cyc(1'b1, 32'h7000, 32'h600, 1, 1'b0);
        chk("byp_count", 64'(count), 64'd0);
`endif

        // random traffic
        for (int i = 0; i < 300; i++)
            cyc(($urandom % 4) != 0, $urandom, $urandom, int'($urandom_range(0, DW)),
                ($urandom % 40) == 0);

        // reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h8000 + i, 32'h700, 0, 1'b0);
        enq_valid = 1'b1; enq_instr = 32'h8888;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(deq_valid), 64'd0);
        sb.delete();
        @(negedge clk_in);
        rst_n = 1'b1;
        idle(0);
        cyc(1'b1, 32'h9000, 32'h800, 0, 1'b0);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
